led_blinker_multi: RTL and testbench
====================================

LED_BLINKER_MULTI -- requirements
Module: led_blinker_multi

Interface
REQ-001 Parameter N_CH, default 4, number of independent LED channels (>=1).
REQ-002 Parameter CNT_W, default 32, prescaler counter width; SHALL hold DIV0..DIV3 - 1.
REQ-003 Parameters DIV0, DIV1, DIV2, DIV3, defaults 50000000, 5000000, 1000000, 500000, clock cycles per tick for rates 0..3 (1/10/50/100 Hz at 50 MHz); each SHALL be >=2.
REQ-004 Parameter BURST_LEN, default 3, number of on-pulses per burst (>=1).
REQ-005 i_clk  input  1  single clock; all state on rising edge.
REQ-006 i_reset  input  1  asynchronous, active-low reset.
REQ-007 i_mode  input  2*N_CH  per-channel mode, bits [2c+1:2c]: 00 OFF, 01 ON, 10 BLINK, 11 BURST; synchronous to i_clk.
REQ-008 i_rate  input  2*N_CH  per-channel rate select, bits [2c+1:2c] picks tick 0..3; synchronous.
REQ-009 i_trig  input  N_CH  per-channel burst start, single-cycle, synchronous.
REQ-010 o_led  output  N_CH  registered LED drive, 1 = lit.
REQ-011 o_busy  output  N_CH  registered, 1 while channel's burst is running.

Function
REQ-012 Four shared free-running prescalers; counter k counts 0..DIVk-1, wraps to 0; registered tick_k SHALL pulse high for exactly one cycle per DIVk cycles.
REQ-013 Per channel, registered enable en[c] SHALL equal tick selected by i_rate[c] one cycle earlier (one cycle mux latency).
REQ-014 Rate change takes effect on next tick of new rate; prescalers SHALL NOT restart on rate or mode change.
REQ-015 OFF: o_led[c] = 0 on next edge; o_busy[c] = 0.
REQ-016 ON: o_led[c] = 1 on next edge; o_busy[c] = 0.
REQ-017 BLINK: o_led[c] SHALL invert on each edge where en[c] = 1; entering BLINK keeps current o_led value as start; period = 2*DIVk cycles.
REQ-018 BURST FSM states IDLE, RUN; IDLE: o_led[c] = 0, o_busy[c] = 0.
REQ-019 IDLE with i_trig[c] = 1: next edge -> RUN, o_busy[c] = 1, toggle count = 0, o_led stays 0; en[c] in that same cycle ignored.
REQ-020 RUN: each en[c] inverts o_led[c] and increments toggle count (width clog2(2*BURST_LEN)).
REQ-021 RUN: en[c] when toggle count = 2*BURST_LEN-1 -> o_led[c] = 0, o_busy[c] = 0, IDLE, same edge.
REQ-022 i_trig[c] during RUN SHALL be ignored (no restart, no queueing).
REQ-023 Mode leaving 11 during RUN: next edge FSM -> IDLE, o_busy[c] = 0, o_led per new mode.
REQ-024 Mode entering 11 SHALL start in IDLE with o_led[c] = 0.
REQ-025 Channels fully independent; i_trig only relevant in BURST.

Reset
REQ-026 i_reset = 0 SHALL immediately, without a clock edge, force prescalers, ticks, en, toggle counts to 0, FSMs to IDLE, o_led and o_busy to 0.
REQ-027 After i_reset deasserts, prescaler k SHALL reach DIVk-1 after DIVk-1 edges; first BLINK toggle at edge DIVk+2.

Verification (DIV0=4, DIV1=6, DIV2=8, DIV3=10, BURST_LEN=2, N_CH=2)
REQ-028 Release reset, ch0 mode 10 rate 0 -> o_led[0] first rises at edge 6, then toggles every 4 edges; ch1 mode 10 rate 3 -> first rise at edge 12, every 10 edges.
REQ-029 ch0 mode 01 -> o_led[0] = 1 next edge; switch to 00 -> 0 next edge; o_busy[0] stays 0.
REQ-030 ch0 mode 11 rate 0, pulse i_trig[0] -> o_busy[0] = 1 next edge; o_led[0] pattern 1,0,1,0 on four successive ticks; o_busy[0] falls on edge of 4th toggle; o_led[0] then holds 0.
REQ-031 Second i_trig[0] mid-burst -> exactly 4 toggles total; mode to 10 mid-burst -> o_busy[0] = 0 next edge, blinking continues from current o_led value.
REQ-032 i_reset low asynchronously between edges while o_led = 2'b11 and o_busy[0] = 1 -> o_led = 0, o_busy = 0 before next edge; after release, timing per REQ-028.
REQ-033 Change ch0 rate 0 -> 2 mid-blink -> next toggle on next tick_2; ch1 output unaffected.

Source files
------------

// File: rtl/led_blinker_multi.sv
`default_nettype none
// ============================================================================
//  Module   : led_blinker_multi
//  Purpose  : Multi-channel LED driver. Four shared free-running prescalers
//             produce one-cycle ticks. Each channel picks one tick as its
//             enable and drives its LED in one of four modes: OFF, ON,
//             BLINK (toggle on every enable) or BURST (BURST_LEN on-pulses
//             after a trigger).
//  Ports    : i_clk    - single clock, rising edge
//             i_reset  - asynchronous, active-low reset
//             i_mode   - 2 bits per channel: 00 OFF, 01 ON, 10 BLINK, 11 BURST
//             i_rate   - 2 bits per channel: selects tick 0..3
//             i_trig   - 1 bit per channel: burst start, single cycle
//             o_led    - registered LED drive, 1 = lit
//             o_busy   - registered, 1 while the channel's burst is running
//  Revision : 1.0 - initial release
// ============================================================================
module led_blinker_multi #(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 32,
    parameter int DIV0      = 50000000,
    parameter int DIV1      = 5000000,
    parameter int DIV2      = 1000000,
    parameter int DIV3      = 500000,
    parameter int BURST_LEN = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [2*N_CH-1:0] i_mode,
    input  logic [2*N_CH-1:0] i_rate,
    input  logic [N_CH-1:0]   i_trig,
    output logic [N_CH-1:0]   o_led,
    output logic [N_CH-1:0]   o_busy
);

    // Toggle counter covers 2*BURST_LEN edges (on + off per pulse).
    localparam int c_tcnt_w = $clog2(2 * BURST_LEN);
    localparam logic [c_tcnt_w-1:0] c_tcnt_last = c_tcnt_w'(2 * BURST_LEN - 1);

    localparam logic [1:0] c_mode_on    = 2'b01;
    localparam logic [1:0] c_mode_blink = 2'b10;
    localparam logic [1:0] c_mode_burst = 2'b11;

    // Terminal count of each prescaler, indexed by rate select.
    localparam logic [3:0][CNT_W-1:0] c_div_top = {
        CNT_W'(DIV3 - 1), CNT_W'(DIV2 - 1), CNT_W'(DIV1 - 1), CNT_W'(DIV0 - 1)
    };

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } burst_state_t;

    logic [3:0] w_tick;

    // ------------------------------------------------------------------
    // Shared prescalers. The tick is registered from the terminal-count
    // compare, so it lands one edge after the counter reaches DIVk-1.
    // They never restart on mode or rate changes.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 4; k++) begin : g_presc
        logic [CNT_W-1:0] r_cnt;
        logic             r_tick;

        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
            end else begin
                if (r_cnt == c_div_top[k]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                r_tick <= (r_cnt == c_div_top[k]);
            end
        end

        assign w_tick[k] = r_tick;
    end

    // ------------------------------------------------------------------
    // Per-channel enable register and LED / burst logic.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        logic [1:0]          w_mode;
        logic [1:0]          w_rate;
        logic                r_en;
        logic                r_led;
        logic                r_busy;
        logic [c_tcnt_w-1:0] r_tcnt;
        burst_state_t        r_state;

        assign w_mode = i_mode[2*c +: 2];
        assign w_rate = i_rate[2*c +: 2];

        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                r_en    <= 1'b0;
                r_led   <= 1'b0;
                r_busy  <= 1'b0;
                r_tcnt  <= '0;
                r_state <= S_IDLE;
            end else begin
                // One cycle of mux latency between tick and enable.
                r_en <= w_tick[w_rate];

                case (w_mode)
                    c_mode_on: begin
                        r_led   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= S_IDLE;
                    end
                    c_mode_blink: begin
                        // Starts from whatever the LED currently shows.
                        if (r_en) begin
                            r_led <= ~r_led;
                        end
                        r_busy  <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= S_IDLE;
                    end
                    c_mode_burst: begin
                        if (r_state == S_IDLE) begin
                            // Enable is ignored in the trigger cycle; the
                            // first toggle comes from the next enable.
                            r_led  <= 1'b0;
                            r_tcnt <= '0;
                            if (i_trig[c]) begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b1;
                            end else begin
                                r_busy  <= 1'b0;
                            end
                        end else if (r_en) begin
                            // Triggers while running are dropped.
                            if (r_tcnt == c_tcnt_last) begin
                                r_led   <= 1'b0;
                                r_busy  <= 1'b0;
                                r_tcnt  <= '0;
                                r_state <= S_IDLE;
                            end else begin
                                r_led  <= ~r_led;
                                r_tcnt <= r_tcnt + c_tcnt_w'(1);
                            end
                        end
                    end
                    default: begin
                        r_led   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end

        assign o_led[c]  = r_led;
        assign o_busy[c] = r_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_led_blinker_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_blinker_multi
//  Purpose  : Self-checking bench for led_blinker_multi (2 channels,
//             DIV 4/6/8/10, BURST_LEN 2). A cycle model pushes the expected
//             LED/busy state on every rising edge; a checker pops and
//             compares it on the falling edge. Directed checks cover the
//             timing points called out for this block.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_blinker_multi;

    localparam int c_d0 = 4;
    localparam int c_d1 = 6;
    localparam int c_d2 = 8;
    localparam int c_d3 = 10;
    localparam int c_bl = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] mode  = 4'b0;
    logic [3:0] rate  = 4'b0;
    logic [1:0] trig  = 2'b0;
    logic [1:0] led;
    logic [1:0] busy;

    always #5 clk = ~clk;

    led_blinker_multi #(
        .N_CH      (2),
        .CNT_W     (8),
        .DIV0      (c_d0),
        .DIV1      (c_d1),
        .DIV2      (c_d2),
        .DIV3      (c_d3),
        .BURST_LEN (c_bl)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .i_mode  (mode),
        .i_rate  (rate),
        .i_trig  (trig),
        .o_led   (led),
        .o_busy  (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: ticks derived from the edge index since reset.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0]      tick;
        logic [1:0]      en;
        logic [1:0]      led;
        logic [1:0]      busy;
        logic [1:0]      run;
        logic [1:0][2:0] tcnt;
    } mstate_t;

    typedef struct packed {
        logic [1:0] led;
        logic [1:0] busy;
    } exp_t;

    mstate_t m      = '0;
    int      m_edge = 0;
    exp_t    exp_q[$];

    function automatic int div_of(input int k);
        case (k)
            0:       return c_d0;
            1:       return c_d1;
            2:       return c_d2;
            default: return c_d3;
        endcase
    endfunction

    function automatic mstate_t step(input mstate_t s, input int e,
                                     input logic [3:0] md, input logic [3:0] rt,
                                     input logic [1:0] tg);
        mstate_t n;
        n = s;
        for (int k = 0; k < 4; k++) n.tick[k] = ((e % div_of(k)) == 0);
        for (int c = 0; c < 2; c++) begin
            n.en[c] = s.tick[rt[2*c +: 2]];
            case (md[2*c +: 2])
                2'b00: begin
                    n.led[c] = 1'b0; n.busy[c] = 1'b0; n.run[c] = 1'b0; n.tcnt[c] = 3'd0;
                end
                2'b01: begin
                    n.led[c] = 1'b1; n.busy[c] = 1'b0; n.run[c] = 1'b0; n.tcnt[c] = 3'd0;
                end
                2'b10: begin
                    if (s.en[c]) n.led[c] = ~s.led[c];
                    n.busy[c] = 1'b0; n.run[c] = 1'b0; n.tcnt[c] = 3'd0;
                end
                default: begin
                    if (!s.run[c]) begin
                        n.led[c]  = 1'b0;
                        n.tcnt[c] = 3'd0;
                        n.run[c]  = tg[c];
                        n.busy[c] = tg[c];
                    end else if (s.en[c]) begin
                        if (s.tcnt[c] == 3'(2*c_bl - 1)) begin
                            n.led[c] = 1'b0; n.busy[c] = 1'b0; n.run[c] = 1'b0; n.tcnt[c] = 3'd0;
                        end else begin
                            n.led[c]  = ~s.led[c];
                            n.tcnt[c] = s.tcnt[c] + 3'd1;
                        end
                    end
                end
            endcase
        end
        return n;
    endfunction

    function automatic exp_t to_exp(input mstate_t s);
        exp_t x;
        x.led  = s.led;
        x.busy = s.busy;
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m      <= '0;
            m_edge <= 0;
        end else begin
            m      <= step(m, m_edge + 1, mode, rate, trig);
            m_edge <= m_edge + 1;
            exp_q.push_back(to_exp(step(m, m_edge + 1, mode, rate, trig)));
        end
    end

    // Scoreboard checker, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            chk("sb_led",  32'(led),  32'(exp_q[0].led));
            chk("sb_busy", 32'(busy), 32'(exp_q[0].busy));
            void'(exp_q.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus and observation helpers.
    // ------------------------------------------------------------------
    int rise0 = -1;
    int rise1 = -1;
    int togs  = 0;

    task automatic run_watch(input int n);
        logic p0;
        p0 = led[0];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rise0 < 0 && led[0]) rise0 = m_edge;
            if (rise1 < 0 && led[1]) rise1 = m_edge;
            if (led[0] != p0) togs++;
            p0 = led[0];
        end
    endtask

    task automatic wait_led0();
        for (int i = 0; i < 20 && !led[0]; i++) @(negedge clk);
        chk("wait_led0", 32'(led[0]), 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        mode = {2'b10, 2'b10};
        rate = {2'd3, 2'd0};
        repeat (3) @(negedge clk);
        chk("rst_led",  32'(led),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Blink timing from reset release.
        rise0 = -1; rise1 = -1;
        rst_n = 1'b1;
        run_watch(30);
        chk("rise0_edge", 32'(rise0), 32'd6);
        chk("rise1_edge", 32'(rise1), 32'd12);

        // Rate change mid-blink on ch0 only.
        rate[1:0] = 2'd2;
        run_watch(30);

        // ON then OFF.
        mode[1:0] = 2'b01;
        @(negedge clk);
        chk("on_led",  32'(led[0]),  32'd1);
        chk("on_busy", 32'(busy[0]), 32'd0);
        mode[1:0] = 2'b00;
        @(negedge clk);
        chk("off_led",  32'(led[0]),  32'd0);
        chk("off_busy", 32'(busy[0]), 32'd0);

        // Single burst.
        mode[1:0] = 2'b11;
        rate[1:0] = 2'd0;
        run_watch(3);
        chk("burst_idle_led", 32'(led[0]), 32'd0);
        trig[0] = 1'b1;
        togs = 0;
        run_watch(1);
        trig[0] = 1'b0;
        chk("burst_busy_rise", 32'(busy[0]), 32'd1);
        chk("burst_led_start", 32'(led[0]),  32'd0);
        run_watch(24);
        chk("burst_toggles",   32'(togs),    32'd4);
        chk("burst_done_busy", 32'(busy[0]), 32'd0);
        chk("burst_done_led",  32'(led[0]),  32'd0);

        // Retrigger during a burst is ignored.
        trig[0] = 1'b1;
        togs = 0;
        run_watch(1);
        trig[0] = 1'b0;
        run_watch(6);
        trig[0] = 1'b1;
        run_watch(1);
        trig[0] = 1'b0;
        run_watch(24);
        chk("retrig_toggles", 32'(togs),    32'd4);
        chk("retrig_busy",    32'(busy[0]), 32'd0);

        // Leave BURST mid-run for BLINK.
        trig[0] = 1'b1;
        run_watch(1);
        trig[0] = 1'b0;
        wait_led0();
        mode[1:0] = 2'b10;
        @(negedge clk);
        chk("exit_burst_busy", 32'(busy[0]), 32'd0);
        run_watch(12);

        // Asynchronous reset between edges.
        mode = {2'b01, 2'b11};
        rate[1:0] = 2'd0;
        run_watch(2);
        trig[0] = 1'b1;
        run_watch(1);
        trig[0] = 1'b0;
        wait_led0();
        chk("pre_rst_led",  32'(led),     32'd3);
        chk("pre_rst_busy", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_led",  32'(led),  32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        mode = {2'b10, 2'b10};
        rate = {2'd3, 2'd0};
        repeat (2) @(negedge clk);
        rise0 = -1; rise1 = -1;
        rst_n = 1'b1;
        run_watch(30);
        chk("rerise0_edge", 32'(rise0), 32'd6);
        chk("rerise1_edge", 32'(rise1), 32'd12);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
